// File: rtl/tile_game_ctrl.sv
// Tile-tapping game controller: six-row scrolling tile buffer, lane-button scoring,
// speed ramp with score, and per-pixel classification of unhit/hit tiles.
module tile_game_ctrl #(
    parameter int ROW_H    = 96,
    parameter int LANE_W   = 160,
    parameter int SPD_STEP = 16,
    parameter int SPD_MAX  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic       frame_tick,
    input  logic [9:0] x_loc,
    input  logic [9:0] y_loc,
    input  logic       video_on,
    output logic       tile_px,
    output logic       hit_px,
    output logic [1:0] state,
    output logic [9:0] score
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic [9:0]  SCORE_MAX  = 10'd999;
    localparam logic [9:0]  ROW_H_V    = 10'(ROW_H);
    localparam logic [9:0]  SPD_STEP_V = 10'(SPD_STEP);
    localparam logic [9:0]  SPD_MAX_V  = 10'(SPD_MAX);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    state_t          state_q, state_d;
    logic [9:0]      score_q, score_d;
    logic [9:0]      off_q, off_d;
    logic [5:0]      valid_q, valid_d;
    logic [5:0]      hit_q, hit_d;
    logic [5:0][1:0] lane_q, lane_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [3:0]      btn_q, btn_d;

    logic [9:0]      level;
    logic [9:0]      speed;
    logic [9:0]      sum;
    logic [3:0]      btn_edge;
    logic            target_ok;
    logic [2:0]      target_idx;
    logic            hit_now;
    logic            miss;
    logic            shift;
    logic [5:0]      hit_flags;

    logic [11:0]     y_rel;
    logic            pix_row_ok;
    logic [2:0]      pix_row;
    logic [1:0]      pix_lane;
    logic [10:0]     x_lo;
    logic            pix_on;

    assign state = state_q;
    assign score = score_q;

    always_comb begin
        level = score_q / SPD_STEP_V;
        speed = (level >= SPD_MAX_V) ? SPD_MAX_V : level + 10'd1;
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        off_d      = off_q;
        valid_d    = valid_q;
        hit_d      = hit_q;
        lane_d     = lane_q;
        btn_d      = btn;
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        btn_edge   = btn & ~btn_q;
        target_ok  = 1'b0;
        target_idx = 3'd0;
        hit_now    = 1'b0;
        miss       = 1'b0;
        shift      = 1'b0;
        hit_flags  = hit_q;
        sum        = off_q + speed;

        // Ascending scan leaves the lowest-on-screen (highest index) eligible row as target.
        for (int k = 1; k < 6; k++) begin
            if (valid_q[k] && !hit_q[k]) begin
                target_ok  = 1'b1;
                target_idx = 3'(k);
            end
        end

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = '0;
                    off_d   = '0;
                    valid_d = '0;
                    hit_d   = '0;
                    lane_d  = '0;
                end
            end
            PLAY: begin
                if (btn_edge != 4'd0 && target_ok) begin
                    if ($onehot(btn_edge) && btn_edge[lane_q[target_idx]]) begin
                        hit_now = 1'b1;
                    end else begin
                        miss = 1'b1;
                    end
                end
                if (hit_now) begin
                    hit_flags[target_idx] = 1'b1;
                end
                if (frame_tick && sum >= ROW_H_V) begin
                    shift = 1'b1;
                end
                // The departing row is judged after this cycle's hit has been applied.
                if (shift && valid_q[5] && !hit_flags[5]) begin
                    miss = 1'b1;
                end

                if (miss) begin
                    state_d = OVER;
                end else begin
                    hit_d = hit_flags;
                    if (frame_tick) begin
                        off_d = shift ? sum - ROW_H_V : sum;
                    end
                    if (shift) begin
                        valid_d = {valid_q[4:0], 1'b1};
                        hit_d   = {hit_flags[4:0], 1'b0};
                        lane_d  = {lane_q[4:0], lfsr_q[1:0]};
                    end
                    if (hit_now && score_q != SCORE_MAX) begin
                        score_d = score_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            score_q <= '0;
            off_q   <= '0;
            valid_q <= '0;
            hit_q   <= '0;
            lane_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            off_q   <= off_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            lane_q  <= lane_d;
            lfsr_q  <= lfsr_d;
            btn_q   <= btn_d;
        end
    end

    // Offsetting y by one row height keeps the partially visible row 0 non-negative.
    always_comb begin
        y_rel      = {2'b00, y_loc} + 12'(ROW_H) - {2'b00, off_q};
        pix_row_ok = 1'b0;
        pix_row    = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (y_rel >= 12'(k * ROW_H) && y_rel < 12'((k + 1) * ROW_H)) begin
                pix_row_ok = 1'b1;
                pix_row    = 3'(k);
            end
        end
        pix_lane = lane_q[pix_row];
        x_lo     = 11'(pix_lane) * 11'(LANE_W);
        pix_on   = video_on && (state_q != IDLE) && (y_loc < 10'd480) && pix_row_ok &&
                   valid_q[pix_row] && ({1'b0, x_loc} >= x_lo) &&
                   ({1'b0, x_loc} < x_lo + 11'(LANE_W));
        tile_px  = pix_on && !hit_q[pix_row];
        hit_px   = pix_on && hit_q[pix_row];
    end

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Testbench for tile_game_ctrl: directed game scenarios checked against hand values
// and a small behavioural game model for tile lanes and screen positions.
module tb_tile_game_ctrl;

    localparam int ROW_H    = 96;
    localparam int LANE_W   = 160;
    localparam int SPD_STEP = 16;
    localparam int SPD_MAX  = 6;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic       frame_tick;
    logic [9:0] x_loc;
    logic [9:0] y_loc;
    logic       video_on;
    logic       tile_px;
    logic       hit_px;
    logic [1:0] state;
    logic [9:0] score;

    bit clk_run = 1'b1;
    int checks  = 0;
    int errors  = 0;

    int          m_state;
    int          m_score;
    int          m_off;
    int          m_hits;
    int          m_valid[6];
    int          m_hit[6];
    int          m_lane[6];
    logic [15:0] m_lfsr;
    logic [3:0]  m_btnq;

    tile_game_ctrl #(
        .ROW_H(ROW_H), .LANE_W(LANE_W), .SPD_STEP(SPD_STEP), .SPD_MAX(SPD_MAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .frame_tick(frame_tick),
        .x_loc(x_loc), .y_loc(y_loc), .video_on(video_on),
        .tile_px(tile_px), .hit_px(hit_px), .state(state), .score(score)
    );

    // The clock can be held high so long pixel sweeps do not advance the game.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic int speedOf(input int sc);
        int s;
        s = 1 + sc / SPD_STEP;
        return (s > SPD_MAX) ? SPD_MAX : s;
    endfunction

    function automatic int laneCenter(input int l);
        return l * LANE_W + LANE_W / 2;
    endfunction

    function automatic logic [3:0] laneBtn(input int l);
        logic [3:0] one;
        one = 4'b0001;
        return one << l;
    endfunction

    function automatic int modelTarget();
        for (int k = 5; k >= 1; k--) begin
            if (m_valid[k] != 0 && m_hit[k] == 0) return k;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_state = 0;
        m_score = 0;
        m_off   = 0;
        m_hits  = 0;
        m_lfsr  = 16'hACE1;
        m_btnq  = 4'd0;
        for (int k = 0; k < 6; k++) begin
            m_valid[k] = 0;
            m_hit[k]   = 0;
            m_lane[k]  = 0;
        end
    endtask

    task automatic modelStep(input logic t, input logic [3:0] b, input logic s);
        logic [3:0] e;
        int         tgt;
        int         n_off;
        int         lane0;
        bit         miss;
        bit         hit_now;
        bit         shift;
        int         h[6];
        e     = b & ~m_btnq;
        lane0 = int'(m_lfsr[1:0]);
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                m_score = 0;
                m_off   = 0;
                for (int k = 0; k < 6; k++) begin
                    m_valid[k] = 0;
                    m_hit[k]   = 0;
                    m_lane[k]  = 0;
                end
            end
        end else begin
            tgt     = modelTarget();
            miss    = 0;
            hit_now = 0;
            shift   = 0;
            h       = m_hit;
            if (e != 4'd0 && tgt >= 0) begin
                if ($countones(e) == 1 && e == laneBtn(m_lane[tgt])) hit_now = 1;
                else miss = 1;
            end
            if (hit_now) h[tgt] = 1;
            n_off = m_off;
            if (t) begin
                n_off = m_off + speedOf(m_score);
                if (n_off >= ROW_H) begin
                    n_off = n_off - ROW_H;
                    shift = 1;
                end
            end
            if (shift && m_valid[5] != 0 && h[5] == 0) miss = 1;
            if (miss) begin
                m_state = 2;
            end else begin
                m_off = n_off;
                m_hit = h;
                if (shift) begin
                    for (int k = 5; k >= 1; k--) begin
                        m_valid[k] = m_valid[k-1];
                        m_hit[k]   = m_hit[k-1];
                        m_lane[k]  = m_lane[k-1];
                    end
                    m_valid[0] = 1;
                    m_hit[0]   = 0;
                    m_lane[0]  = lane0;
                end
                if (hit_now) begin
                    m_hits++;
                    if (m_score < 999) m_score++;
                end
            end
        end
        m_btnq = b;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    endtask

    task automatic modelPixel(input int x, input int y, output logic t, output logic h);
        int row;
        t = 1'b0;
        h = 1'b0;
        if (m_state == 0 || y >= 480) return;
        if (y < m_off) row = 0;
        else row = (y - m_off) / ROW_H + 1;
        if (row > 5) return;
        if (m_valid[row] == 0) return;
        if (x >= m_lane[row] * LANE_W && x < (m_lane[row] + 1) * LANE_W) begin
            if (m_hit[row] != 0) h = 1'b1;
            else t = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic [3:0] b, input logic s);
        frame_tick = t;
        btn        = b;
        start      = s;
        @(posedge clk);
        modelStep(t, b, s);
        #1;
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 4'd0, 1'b0);
    endtask

    task automatic probePixel(input int x, input int y);
        clk_run = 1'b0;
        x_loc   = 10'(x);
        y_loc   = 10'(y);
        #1;
        clk_run = 1'b1;
    endtask

    task automatic scanCheck(input string tag);
        int   bad;
        int   xs[6];
        logic t;
        logic h;
        xs      = '{0, 159, 160, 479, 480, 639};
        bad     = 0;
        clk_run = 1'b0;
        for (int y = 0; y < 480; y++) begin
            for (int i = 0; i < 6; i++) begin
                x_loc = 10'(xs[i]);
                y_loc = 10'(y);
                #1;
                modelPixel(xs[i], y, t, h);
                if (tile_px !== t || hit_px !== h) bad++;
            end
        end
        clk_run = 1'b1;
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_lane;
        int         wrong;
        int         tgt;
        int         hits_mark;
        int         y_pre;
        int         x_pre;
        logic       t_exp;
        logic       h_exp;
        bit         press_prev;
        bit         seen16;
        bit         seen17;
        bit         seen80;
        bit         seen81;

        reset = 1'b1; start = 1'b0; btn = 4'd0; frame_tick = 1'b0;
        video_on = 1'b1; x_loc = 10'd0; y_loc = 10'd0;
        seen16 = 0; seen17 = 0; seen80 = 0; seen81 = 0;
        modelReset();
        $display("[TB] tile_game_ctrl bench starting");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_score", 32'(score), 32'd0);
        probePixel(80, 50);
        checkOutput("reset_tile_px", 32'(tile_px), 32'd0);
        reset = 1'b0;

        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("start_state", 32'(state), 32'd1);
        checkOutput("start_score", 32'(score), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        applyStimulus(1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("no_row_press_state", 32'(state), 32'd1);
        checkOutput("no_row_press_score", 32'(score), 32'd0);

        runTicks(95);
        exp_lane = m_lfsr[1:0];
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("first_shift_state", 32'(state), 32'd1);
        probePixel(laneCenter(int'(exp_lane)), 0);
        checkOutput("row0_zero_height", 32'(tile_px), 32'd0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        probePixel(laneCenter(int'(exp_lane)), 0);
        checkOutput("row0_lane_tile", 32'(tile_px), 32'd1);
        probePixel(laneCenter(int'(exp_lane ^ 2'd1)), 0);
        checkOutput("row0_other_lane", 32'(tile_px), 32'd0);
        probePixel(laneCenter(int'(exp_lane)), 1);
        checkOutput("row1_still_empty", 32'(tile_px), 32'd0);

        runTicks(95);
        probePixel(laneCenter(int'(exp_lane)), 50);
        checkOutput("row1_tile_before_hit", 32'(tile_px), 32'd1);
        video_on = 1'b0;
        probePixel(laneCenter(int'(exp_lane)), 50);
        checkOutput("blanked_tile_px", 32'(tile_px), 32'd0);
        video_on = 1'b1;

        applyStimulus(1'b0, laneBtn(int'(exp_lane)), 1'b0);
        checkOutput("hit_score", 32'(score), 32'd1);
        checkOutput("hit_state", 32'(state), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        probePixel(laneCenter(int'(exp_lane)), 50);
        checkOutput("hit_region_hit_px", 32'(hit_px), 32'd1);
        checkOutput("hit_region_tile_px", 32'(tile_px), 32'd0);
        scanCheck("scan_after_hit");

        runTicks(96);
        wrong = (m_lane[1] + 1) % 4;
        applyStimulus(1'b0, laneBtn(wrong), 1'b0);
        checkOutput("wrong_lane_state", 32'(state), 32'd2);
        checkOutput("wrong_lane_score", 32'(score), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        runTicks(10);
        applyStimulus(1'b0, laneBtn(m_lane[1]), 1'b0);
        checkOutput("over_frozen_state", 32'(state), 32'd2);
        checkOutput("over_frozen_score", 32'(score), 32'd1);
        probePixel(laneCenter(int'(exp_lane)), 100);
        checkOutput("over_frozen_offset", 32'(hit_px), 32'd1);
        scanCheck("scan_over_frozen");

        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("restart_state", 32'(state), 32'd1);
        checkOutput("restart_score", 32'(score), 32'd0);
        probePixel(80, 50);
        checkOutput("restart_rows_clear_a", 32'(tile_px), 32'd0);
        probePixel(560, 300);
        checkOutput("restart_rows_clear_b", 32'(tile_px), 32'd0);
        runTicks(192);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("two_button_state", 32'(state), 32'd2);
        checkOutput("two_button_score", 32'(score), 32'd0);

        applyStimulus(1'b0, 4'd0, 1'b1);
        runTicks(671);
        checkOutput("row5_before_leave", 32'(state), 32'd1);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("row5_unhit_miss", 32'(state), 32'd2);

        applyStimulus(1'b0, 4'd0, 1'b1);
        runTicks(671);
        applyStimulus(1'b1, laneBtn(m_lane[5]), 1'b0);
        checkOutput("row5_saved_state", 32'(state), 32'd1);
        checkOutput("row5_saved_score", 32'(score), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("start_in_play_state", 32'(state), 32'd1);
        checkOutput("start_in_play_score", 32'(score), 32'd1);

        press_prev = 0;
        for (int n = 0; n < 60000 && m_score < 999; n++) begin
            tgt = modelTarget();
            if (!press_prev && tgt >= 0) begin
                applyStimulus(1'b1, laneBtn(m_lane[tgt]), 1'b0);
                press_prev = 1;
            end else begin
                applyStimulus(1'b1, 4'd0, 1'b0);
                press_prev = 0;
            end
            if (m_score == 16 && !seen16) begin
                seen16 = 1;
                checkOutput("score_16", 32'(score), 32'd16);
            end
            if (m_score == 17 && !seen17) begin
                seen17 = 1;
                scanCheck("scan_speed2");
            end
            if (m_score == 80 && !seen80) begin
                seen80 = 1;
                checkOutput("score_80", 32'(score), 32'd80);
            end
            if (m_score == 81 && !seen81) begin
                seen81 = 1;
                scanCheck("scan_speed6");
            end
        end
        checkOutput("score_999", 32'(score), 32'd999);
        checkOutput("state_at_999", 32'(state), 32'd1);

        hits_mark = m_hits;
        for (int n = 0; n < 400 && m_hits == hits_mark; n++) begin
            tgt = modelTarget();
            if (!press_prev && tgt >= 0) begin
                applyStimulus(1'b1, laneBtn(m_lane[tgt]), 1'b0);
                press_prev = 1;
            end else begin
                applyStimulus(1'b1, 4'd0, 1'b0);
                press_prev = 0;
            end
        end
        checkOutput("score_saturated", 32'(score), 32'd999);
        checkOutput("state_after_sat", 32'(state), 32'd1);
        scanCheck("scan_saturated");

        y_pre = m_off + ROW_H / 2;
        x_pre = laneCenter(m_lane[1]);
        probePixel(x_pre, y_pre);
        modelPixel(x_pre, y_pre, t_exp, h_exp);
        checkOutput("pre_reset_pixel", 32'({tile_px, hit_px}), 32'({t_exp, h_exp}));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_state", 32'(state), 32'd0);
        checkOutput("mid_reset_score", 32'(score), 32'd0);
        probePixel(x_pre, y_pre);
        checkOutput("mid_reset_pixels", 32'({tile_px, hit_px}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        probePixel(x_pre, y_pre);
        checkOutput("held_reset_pixels", 32'({tile_px, hit_px}), 32'd0);
        reset = 1'b0;
        modelReset();

        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("relaunch_state", 32'(state), 32'd1);
        checkOutput("relaunch_score", 32'(score), 32'd0);
        runTicks(97);
        scanCheck("scan_relaunch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
